wb_host_master: RTL
===================

Name: wb_host_master

Overview:
- Wishbone classic single-transfer initiator. It is the master end of the 32-bit Wishbone slave port that the user project wrapper exposes as wbs_*.
- Converts a valid/ready command stream into one bus cycle per command and returns read data or error through a valid/ready response stream.
- Used as the on-chip/test-harness driver of the AES slave (key, data and status register access), with a bounded ack timeout.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width; SEL_W = DATA_W/8.
- TIMEOUT_CYCLES, 255, max cycles with cyc/stb asserted before abort; legal range 1..65535.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when cmd_valid_i and cmd_ready_o are both high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_W  byte address.
- cmd_dat_i  in  DATA_W  write data.
- cmd_sel_i  in  SEL_W  byte enables.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  DATA_W  read data; 0 for writes and on error.
- rsp_err_o  out  1  timeout abort.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  SEL_W  Wishbone byte selects.
- wbm_adr_o  out  ADDR_W  Wishbone address.
- wbm_dat_o  out  DATA_W  Wishbone write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  DATA_W  slave read data.
- txn_count_o  out  CNT_W  completed transfers (acked or timed out).
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered, except cmd_ready_o = (state == IDLE) and busy_o.
- Reset values: state IDLE, all wbm_* outputs 0, rsp_valid_o 0, rsp_dat_o 0, rsp_err_o 0, txn_count_o 0, timeout counter 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On accept, latch we/adr/dat/sel into the wbm_* registers, set cyc = stb = 1, clear the timeout counter, go to BUS.
  - cyc/stb are therefore high in the cycle after the accept edge.
- BUS:
  - cyc, stb, we, adr, dat and sel are held stable.
  - The counter increments every cycle in BUS.
  - If wbm_ack_i is sampled high at an edge:
    - cyc = stb = 0 (no wait cycle between transfers is guaranteed).
    - rsp_dat_o = wbm_dat_i for a read, 0 for a write.
    - rsp_err_o = 0, rsp_valid_o = 1, txn_count_o increments, go to RESP.
  - Else if the counter equals TIMEOUT_CYCLES-1:
    - cyc = stb = 0, rsp_dat_o = 0, rsp_err_o = 1, rsp_valid_o = 1, txn_count_o increments, go to RESP.
  - Ack and timeout at the same edge: ack wins, no error.
- RESP:
  - rsp_* held stable until rsp_ready_i is high at an edge.
  - Then rsp_valid_o = 0 and go to IDLE; the next command can be accepted one cycle later.
- Minimum latency:
  - Accept at edge N, with a slave that acks combinationally in the first stb cycle.
  - ack sampled at edge N+1, rsp_valid_o high after edge N+1.
  - A new command can be accepted at edge N+3 with rsp_ready_i tied high.
- wbm_ack_i outside BUS is ignored; it causes no state change and no count.
- txn_count_o wraps modulo 2^CNT_W.
- Reset asserted mid-transfer: cyc/stb drop immediately (asynchronous); any pending command or response is discarded.
- Only one transfer is outstanding at a time. No burst, no pipelined mode, no retry/err_i.

Decomposition:
- Package wb_host_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - default widths;
  - the localparam for timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- No sub-module. The timeout counter is inline; a separate wb_timeout_cnt is not warranted.

Test Plan:
- Write, slave acks after 2 wait states:
  - Stimulus: cmd_we=1, cmd_adr=0x3000_0004, cmd_dat=0xDEAD_BEEF, sel=0xF.
  - Bus check: cyc/stb high for exactly 3 cycles with adr/dat/sel stable.
  - Response: rsp_valid=1, rsp_err=0, rsp_dat=0, txn_count=1.
- Read, combinational ack, slave returns 0x2B7E_1516 for adr 0x3000_0010:
  - Response: rsp_dat=0x2B7E_1516 at minimum latency (rsp_valid after accept+1 edge).
- Timeout, slave never acks, TIMEOUT_CYCLES=8:
  - Bus check: cyc high for exactly 8 cycles, then drops.
  - Response: rsp_err=1, rsp_dat=0. A following read completes normally.
- Ack on the timeout edge, TIMEOUT_CYCLES=8, ack in the 8th cycle:
  - Response: rsp_err=0 with slave data.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after the response while cmd_valid is held high with a new command.
  - Required: cmd_ready stays 0 and rsp_* stay stable. Second command accepted one cycle after rsp_ready=1.
- Reset mid-transfer:
  - Stimulus: assert wb_rst_ni=0 while in BUS.
  - Required: cyc/stb/rsp_valid go 0 without a clock edge, txn_count=0. After release, cmd_ready=1 and a fresh write completes.

Source files
------------

// File: rtl/wb_host_pkg.sv
// Shared types and default sizing for the Wishbone host master.
package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_CNT_W          = 16;

    // Counter must be able to represent TIMEOUT_CYCLES-1 for every legal value.
    function automatic int to_cnt_w(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

    localparam int DEF_TO_W = to_cnt_w(DEF_TIMEOUT_CYCLES);

endpackage

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: one bus cycle per accepted command,
// read data or a timeout error is returned on a valid/ready response channel.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_W-1:0]     cmd_adr_i,
    input  logic [DATA_W-1:0]     cmd_dat_i,
    input  logic [DATA_W/8-1:0]   cmd_sel_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_dat_o,
    output logic                  rsp_err_o,

    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [DATA_W/8-1:0]   wbm_sel_o,
    output logic [ADDR_W-1:0]     wbm_adr_o,
    output logic [DATA_W-1:0]     wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic [DATA_W-1:0]     wbm_dat_i,

    output logic [CNT_W-1:0]      txn_count_o,
    output logic                  busy_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int TO_W  = to_cnt_w(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_finish;
    logic              w_release;

    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_dat;
    logic [TO_W-1:0]   r_to_cnt;

    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_dat;
    logic [CNT_W-1:0]  r_txn_count;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Ack takes priority over expiry, so an ack on the last allowed cycle is a success.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_finish  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid_i) begin
                    w_accept = 1'b1;
                    w_next   = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i || (r_to_cnt == TO_LAST)) begin
                    w_finish = 1'b1;
                    w_next   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= '0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (w_accept) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= cmd_we_i;
            r_sel <= cmd_sel_i;
            r_adr <= cmd_adr_i;
            r_dat <= cmd_dat_i;
        end else if (w_finish) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if (r_state == BUS) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Writes and timeouts return zero data so stale read data never leaks out.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_dat   <= '0;
            r_txn_count <= '0;
        end else if (w_finish) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ~wbm_ack_i;
            r_rsp_dat   <= (wbm_ack_i && !r_we) ? wbm_dat_i : '0;
            r_txn_count <= r_txn_count + CNT_W'(1);
        end else if (w_release) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign cmd_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);

    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = r_sel;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_dat_o   = r_rsp_dat;
    assign txn_count_o = r_txn_count;

endmodule
